// File: rtl/load_store_unit.sv
// Load/store unit: the only master of a word-wide data memory.
// Accepts one request at a time, does lane extraction and extension for
// loads, read-modify-write for sub-word stores, and flags misaligned or
// illegal-size accesses without touching memory.
module load_store_unit #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_ra,
  output logic [ADDR_W-1:0] mem_wa,
  output logic [DATA_W-1:0] mem_wd,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wd_q, mem_wd_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic                req_bad;
  logic [4:0]          shamt;
  logic [DATA_W-1:0]   rd_sh, rd_ext, lane_mask, merged;

  // Memory only ever sees word-aligned word accesses.
  assign mem_ra     = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wa     = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_size   = 2'b00;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_wd     = mem_wd_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign req_ready  = RSTn && (state_q == S_IDLE);

  // Alignment check on the incoming request; lane datapath on the latched one.
  always_comb begin
    req_bad   = (req_size == 2'd3) ||
                (req_size == 2'd0 && req_addr[1:0] != 2'b00) ||
                (req_size == 2'd1 && req_addr[0]);
    shamt     = {addr_q[1:0], 3'b000};
    rd_sh     = mem_rd >> shamt;
    case (size_q)
      2'd1:    rd_ext = {{16{sgn_q & rd_sh[15]}}, rd_sh[15:0]};
      2'd2:    rd_ext = {{24{sgn_q & rd_sh[7]}},  rd_sh[7:0]};
      default: rd_ext = mem_rd;
    endcase
    lane_mask = ((size_q == 2'd1) ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
    merged    = (mem_rd & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_wd_d     = mem_wd_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        sgn_d   = req_signed;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        if (req_bad) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else if (req_we && req_size == 2'd0) begin
          state_d  = S_WR_ISSUE;
          mem_we_d = 1'b1;
          mem_wd_d = req_wdata;
        end else begin
          // Loads and sub-word stores both start with a word read.
          state_d  = S_RD_ISSUE;
          mem_re_d = 1'b1;
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (we_q) begin
          state_d  = S_WR_ISSUE;
          mem_we_d = 1'b1;
          mem_wd_d = merged;
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = rd_ext;
        end
      end
      S_WR_ISSUE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      sgn_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_wd_q     <= mem_wd_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model on the memory ports and a
// byte-array reference model of memory contents and response rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_re, mem_we;
  logic [11:0] mem_ra, mem_wa;
  logic [31:0] mem_wd, mem_rd;
  logic [1:0]  mem_size;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rd, last_wd;

  load_store_unit #(.ADDR_W(12), .DATA_W(32)) dut (
    .CLK(clk), .RSTn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_ra(mem_ra), .mem_wa(mem_wa),
    .mem_wd(mem_wd), .mem_size(mem_size), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction

  // Data memory: word array, registered read.
  logic [31:0] tb_mem [1024];
  logic        seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= init_word(i);
      seeded <= 1'b1;
    end else begin
      if (mem_we) tb_mem[mem_wa[11:2]] <= mem_wd;
      if (mem_re) mem_rd <= tb_mem[mem_ra[11:2]];
    end
  end

  // Reference model: memory as bytes.
  logic [7:0] ref_mem [4096];

  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
  endfunction

  function automatic logic is_err(logic [1:0] sz, logic [11:0] a);
    return (sz == 2'd3) || (sz == 2'd0 && a[1:0] != 2'b00) ||
           (sz == 2'd1 && a[0]);
  endfunction

  function automatic logic [31:0] ref_load(logic [1:0] sz, logic sg, logic [11:0] a);
    int n = nbytes(sz);
    logic [31:0] v = 32'h0;
    logic [31:0] lim;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
    if (n < 4) begin
      lim = (32'd1 << (8 * n)) - 32'd1;
      if (sg && v[8 * n - 1]) v = v | ~lim;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [11:0] a, input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[int'(a) + i] = wd[8 * i +: 8];
  endtask

  function automatic logic [31:0] ref_word(int widx);
    return {ref_mem[4 * widx + 3], ref_mem[4 * widx + 2],
            ref_mem[4 * widx + 1], ref_mem[4 * widx]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request from the IDLE state to just after its response pulse.
  // Cycle c is observed 1 time unit after the c-th edge following acceptance.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [11:0] a, input logic [31:0] wd);
    logic e;
    logic [31:0] er, ewd, ra_s, wa_s, wd_s;
    int el, ere, ewe, lat, re_c, we_c, w;
    e = is_err(sz, a);
    er = 32'h0;
    if (e) begin el = 0; ere = -1; ewe = -1; end
    else if (!we) begin er = ref_load(sz, sg, a); el = 2; ere = 0; ewe = -1; end
    else begin
      ref_store(sz, a, wd);
      if (sz == 2'd0) begin el = 1; ere = -1; ewe = 0; end
      else begin el = 3; ere = 0; ewe = 2; end
    end
    ewd = ref_word(int'(a[11:2]));
    w = 0;
    while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
    chk("ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom; req_size = 2'($urandom);
    req_signed = $urandom; req_addr = 12'($urandom); req_wdata = $urandom;
    lat = -1; re_c = -1; we_c = -1;
    ra_s = 0; wa_s = 0; wd_s = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (mem_re && mem_we) chk("re_we_excl", 32'd1, 32'd0);
      if (mem_re && re_c < 0) begin re_c = c; ra_s = 32'(mem_ra); end
      if (mem_we && we_c < 0) begin we_c = c; wa_s = 32'(mem_wa); wd_s = mem_wd; end
      if (resp_valid) begin lat = c; break; end
    end
    chk("latency", 32'(lat), 32'(el));
    chk("re_cycle", 32'(re_c), 32'(ere));
    chk("we_cycle", 32'(we_c), 32'(ewe));
    chk("rdata", resp_rdata, er);
    chk("err", 32'(resp_err), 32'(e));
    if (re_c >= 0) chk("mem_ra", ra_s, 32'({a[11:2], 2'b00}));
    if (we_c >= 0) begin
      chk("mem_wa", wa_s, 32'({a[11:2], 2'b00}));
      chk("mem_wd", wd_s, ewd);
    end
    last_rd = resp_rdata; last_wd = wd_s;
    @(posedge clk); #1;
    chk("pulse_one", 32'(resp_valid), 32'd0);
    chk("rdata_hold", resp_rdata, er);
  endtask

  initial begin
    int re_seen, we_seen, rv_seen;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[4 * i]     = init_word(i)[7:0];
      ref_mem[4 * i + 1] = init_word(i)[15:8];
      ref_mem[4 * i + 2] = init_word(i)[23:16];
      ref_mem[4 * i + 3] = init_word(i)[31:24];
    end
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 12'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_ra", 32'(mem_ra), 32'd0);
    chk("rst_mem_wa", 32'(mem_wa), 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("mem_size", 32'(mem_size), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Directed sequence on word 0x010.
    do_req(1'b1, 2'd0, 1'b0, 12'h010, 32'h1122_3344);
    do_req(1'b0, 2'd0, 1'b0, 12'h010, 32'h0);
    chk("lw_010", last_rd, 32'h1122_3344);
    do_req(1'b1, 2'd2, 1'b0, 12'h012, 32'h0000_00AA);
    chk("sb_merge", last_wd, 32'h11AA_3344);
    do_req(1'b0, 2'd2, 1'b1, 12'h012, 32'h0);
    chk("lb_signed", last_rd, 32'hFFFF_FFAA);
    do_req(1'b0, 2'd2, 1'b0, 12'h012, 32'h0);
    chk("lb_unsigned", last_rd, 32'h0000_00AA);
    do_req(1'b0, 2'd1, 1'b1, 12'h012, 32'h0);
    chk("lh_signed_hi", last_rd, 32'h0000_11AA);
    do_req(1'b1, 2'd1, 1'b0, 12'h010, 32'h0000_8001);
    chk("sh_merge", last_wd, 32'h11AA_8001);
    do_req(1'b0, 2'd1, 1'b1, 12'h010, 32'h0);
    chk("lh_signed", last_rd, 32'hFFFF_8001);
    do_req(1'b0, 2'd1, 1'b0, 12'h010, 32'h0);
    chk("lh_unsigned", last_rd, 32'h0000_8001);

    // Misaligned and illegal-size requests.
    do_req(1'b0, 2'd0, 1'b0, 12'h013, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 12'h011, 32'hFFFF_FFFF);
    do_req(1'b0, 2'd3, 1'b0, 12'h010, 32'h0);
    chk("err_no_write", tb_mem[4], ref_word(4));

    // Randomized traffic over a small window to force overlap.
    for (int n = 0; n < 300; n++)
      do_req(1'($urandom), 2'($urandom), 1'($urandom),
             12'($urandom_range(0, 63)), $urandom);

    // Reset in RD_WAIT of a byte store: no response, no write.
    re_seen = 0; we_seen = 0; rv_seen = 0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 12'h014; req_wdata = 32'h0000_005A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_re", 32'(mem_re), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (mem_we) we_seen++;
      if (mem_re) re_seen++;
      if (resp_valid) rv_seen++;
    end
    chk("abort_ready_low", 32'(req_ready), 32'd0);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (c == 0) chk("abort_ready", 32'(req_ready), 32'd1);
      if (mem_we) we_seen++;
      if (mem_re) re_seen++;
      if (resp_valid) rv_seen++;
    end
    chk("abort_no_we", 32'(we_seen), 32'd0);
    chk("abort_no_re", 32'(re_seen), 32'd0);
    chk("abort_no_resp", 32'(rv_seen), 32'd0);
    chk("abort_word", tb_mem[5], ref_word(5));
    do_req(1'b0, 2'd0, 1'b0, 12'h014, 32'h0);

    for (int i = 0; i < 16; i++) chk("final_mem", tb_mem[i], ref_word(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
